// File: rtl/calc_key_ctrl_if.sv
// Keypad-side bus of calc_key_ctrl: key code, asynchronous validate strobe
// and the one-cycle acknowledge returned for every accepted key.
interface calc_key_ctrl_if;
    logic [7:0] data;
    logic       validate;
    logic       key_ack;

    modport master (
        output data,
        output validate,
        input  key_ack
    );

    modport slave (
        input  data,
        input  validate,
        output key_ack
    );
endinterface

// File: rtl/calc_key_ctrl.sv
// Keypad front end of the two-operand signed calculator: synchronises key
// strobes, edits operands A/B, and drives the ALU and blanking display outputs.
// Define AUTO_OFF_EN to build the inactivity auto power-off counter.
module calc_key_ctrl #(
    parameter int unsigned BLINK_HALF   = 25000000,
    parameter int unsigned IDLE_TIMEOUT = 1500000000
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    calc_key_ctrl_if.slave        kp,
    output logic [7:0]            mag_A,
    output logic [7:0]            mag_B,
    output logic                  signalA,
    output logic                  signalB,
    output logic                  opr,
    output logic [7:0]            out_A,
    output logic [7:0]            out_B,
    output logic [2:0]            state_o
);

    localparam int unsigned BLINK_PERIOD = 2 * BLINK_HALF;
    localparam int unsigned BW           = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [BW-1:0] BLINK_HALF_C = BW'(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_PERIOD - 1);

    localparam logic [7:0] K_SIGN   = 8'd12;
    localparam logic [7:0] K_DEF_A  = 8'd15;
    localparam logic [7:0] K_CLEAR  = 8'd16;
    localparam logic [7:0] K_ON_OFF = 8'd18;
    localparam logic [7:0] K_DEF_B  = 8'd19;
    localparam logic [7:0] K_SUM    = 8'd26;
    localparam logic [7:0] K_MINUS  = 8'd30;
    localparam logic [7:0] BLANK    = 8'd100;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_EDIT_A = 3'd2,
        ST_EDIT_B = 3'd3
    } state_t;

    function automatic logic [7:0] shift_digit(input logic [7:0] mag, input logic [7:0] key);
        return ((mag % 8'd10) * 8'd10) + key;
    endfunction

    logic          r_sync1;
    logic          r_sync2;
    logic          r_hist;
    logic [1:0]    r_settle;
    logic          r_evt;
    logic [7:0]    r_data;
    logic          w_evt;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_magA, r_magB;
    logic          r_sA, r_sB, r_opr, r_ack;
    logic [7:0]    w_magA_nxt, w_magB_nxt;
    logic          w_sA_nxt, w_sB_nxt, w_opr_nxt, w_ack_nxt;
    logic          w_blink_rst;
    logic          w_edit_nxt;
    logic [BW-1:0] r_blink;
    logic [7:0]    r_outA, r_outB;
    logic          w_timeout;

    // ---- Stage: validate synchroniser, edge detect, key capture ----
    // The history flop is held at 1 until the synchroniser has flushed its
    // reset zeros, so a strobe held high across reset never looks like an edge.
    assign w_evt = r_sync2 & ~r_hist;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_hist   <= 1'b1;
            r_settle <= 2'd0;
            r_evt    <= 1'b0;
        end else begin
            r_sync1 <= kp.validate;
            r_sync2 <= r_sync1;
            r_hist  <= (r_settle == 2'd2) ? r_sync2 : 1'b1;
            if (r_settle != 2'd2) begin
                r_settle <= r_settle + 2'd1;
            end
            r_evt <= w_evt;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_evt) begin
            r_data <= kp.data;
        end
    end

    // ---- Stage: key decode and operand state machine ----
    always_comb begin
        w_state_nxt = r_state;
        w_magA_nxt  = r_magA;
        w_magB_nxt  = r_magB;
        w_sA_nxt    = r_sA;
        w_sB_nxt    = r_sB;
        w_opr_nxt   = r_opr;
        w_ack_nxt   = 1'b0;
        w_blink_rst = 1'b0;

        if (r_evt) begin
            if (r_state == ST_OFF) begin
                if (r_data == K_ON_OFF) begin
                    w_state_nxt = ST_IDLE;
                    w_magA_nxt  = 8'd0;
                    w_magB_nxt  = 8'd0;
                    w_sA_nxt    = 1'b0;
                    w_sB_nxt    = 1'b0;
                    w_opr_nxt   = 1'b0;
                    w_ack_nxt   = 1'b1;
                end
            end else begin
                case (r_data)
                    K_ON_OFF: begin
                        w_state_nxt = ST_OFF;
                        w_magA_nxt  = 8'd0;
                        w_magB_nxt  = 8'd0;
                        w_sA_nxt    = 1'b0;
                        w_sB_nxt    = 1'b0;
                        w_opr_nxt   = 1'b0;
                        w_ack_nxt   = 1'b1;
                    end
                    K_CLEAR: begin
                        w_state_nxt = ST_IDLE;
                        w_magA_nxt  = 8'd0;
                        w_magB_nxt  = 8'd0;
                        w_sA_nxt    = 1'b0;
                        w_sB_nxt    = 1'b0;
                        w_ack_nxt   = 1'b1;
                    end
                    K_DEF_A: begin
                        w_state_nxt = ST_EDIT_A;
                        w_magA_nxt  = 8'd0;
                        w_sA_nxt    = 1'b0;
                        w_blink_rst = 1'b1;
                        w_ack_nxt   = 1'b1;
                    end
                    K_DEF_B: begin
                        w_state_nxt = ST_EDIT_B;
                        w_magB_nxt  = 8'd0;
                        w_sB_nxt    = 1'b0;
                        w_blink_rst = 1'b1;
                        w_ack_nxt   = 1'b1;
                    end
                    K_SUM: begin
                        w_opr_nxt = 1'b0;
                        w_ack_nxt = 1'b1;
                    end
                    K_MINUS: begin
                        w_opr_nxt = 1'b1;
                        w_ack_nxt = 1'b1;
                    end
                    K_SIGN: begin
                        if (r_state == ST_EDIT_A) begin
                            w_sA_nxt  = ~r_sA;
                            w_ack_nxt = 1'b1;
                        end else if (r_state == ST_EDIT_B) begin
                            w_sB_nxt  = ~r_sB;
                            w_ack_nxt = 1'b1;
                        end
                    end
                    default: begin
                        if (r_data <= 8'd9) begin
                            if (r_state == ST_EDIT_A) begin
                                w_magA_nxt = shift_digit(r_magA, r_data);
                                w_ack_nxt  = 1'b1;
                            end else if (r_state == ST_EDIT_B) begin
                                w_magB_nxt = shift_digit(r_magB, r_data);
                                w_ack_nxt  = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end

        // An accepted key in the same cycle beats the inactivity timeout.
        if (!w_ack_nxt && w_timeout) begin
            w_state_nxt = ST_OFF;
            w_magA_nxt  = 8'd0;
            w_magB_nxt  = 8'd0;
            w_sA_nxt    = 1'b0;
            w_sB_nxt    = 1'b0;
            w_opr_nxt   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_magA <= 8'd0;
            r_magB <= 8'd0;
            r_sA   <= 1'b0;
            r_sB   <= 1'b0;
            r_opr  <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_magA <= w_magA_nxt;
            r_magB <= w_magB_nxt;
            r_sA   <= w_sA_nxt;
            r_sB   <= w_sB_nxt;
            r_opr  <= w_opr_nxt;
            r_ack  <= w_ack_nxt;
        end
    end

    assign w_edit_nxt = (w_state_nxt == ST_EDIT_A) || (w_state_nxt == ST_EDIT_B);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_blink <= '0;
        end else if (!w_edit_nxt || w_blink_rst) begin
            r_blink <= '0;
        end else if (r_blink == BLINK_LAST) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + 1'b1;
        end
    end

`ifdef AUTO_OFF_EN
    logic [31:0] r_idle;

    assign w_timeout = (r_state != ST_OFF) && (r_idle == IDLE_TIMEOUT - 1);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_idle <= 32'd0;
        end else if (w_ack_nxt || (r_state == ST_OFF) || w_timeout) begin
            r_idle <= 32'd0;
        end else begin
            r_idle <= r_idle + 32'd1;
        end
    end
`else
    // IDLE_TIMEOUT has no effect in this build.
    assign w_timeout = (IDLE_TIMEOUT == 0) & 1'b0;
`endif

    // ---- Stage: registered display with blanking ----
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_outA <= BLANK;
            r_outB <= BLANK;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_outA <= BLANK;
                    r_outB <= BLANK;
                end
                ST_EDIT_A: begin
                    r_outA <= (r_blink < BLINK_HALF_C) ? BLANK : r_magA;
                    r_outB <= r_magB;
                end
                ST_EDIT_B: begin
                    r_outA <= r_magA;
                    r_outB <= (r_blink < BLINK_HALF_C) ? BLANK : r_magB;
                end
                default: begin
                    r_outA <= r_magA;
                    r_outB <= r_magB;
                end
            endcase
        end
    end

    assign mag_A      = r_magA;
    assign mag_B      = r_magB;
    assign signalA    = r_sA;
    assign signalB    = r_sB;
    assign opr        = r_opr;
    assign out_A      = r_outA;
    assign out_B      = r_outB;
    assign state_o    = r_state;
    assign kp.key_ack = r_ack;

endmodule

// File: tb/tb_calc_key_ctrl.sv
// Scoreboard bench for calc_key_ctrl: a key model predicts each accepted key's
// effect; the monitor compares it against the DUT on every key_ack.
module tb_calc_key_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mag_A, mag_B, out_A, out_B;
    logic       signalA, signalB, opr;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    calc_key_ctrl_if kp();

    calc_key_ctrl #(
        .BLINK_HALF   (4),
        .IDLE_TIMEOUT (20)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .kp       (kp),
        .mag_A    (mag_A),
        .mag_B    (mag_B),
        .signalA  (signalA),
        .signalB  (signalB),
        .opr      (opr),
        .out_A    (out_A),
        .out_B    (out_B),
        .state_o  (state_o)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] a;
        logic [7:0] b;
        logic       sa;
        logic       sb;
        logic       op;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [2:0] m_st = 3'd0;
    logic [7:0] m_a = 8'd0, m_b = 8'd0;
    logic       m_sa = 1'b0, m_sb = 1'b0, m_op = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear_all();
        m_a = 8'd0; m_b = 8'd0; m_sa = 1'b0; m_sb = 1'b0; m_op = 1'b0;
    endtask

    task automatic model_key(input logic [7:0] k, output bit acc);
        acc = 1'b0;
        if (m_st == 3'd0) begin
            if (k == 8'd18) begin m_st = 3'd1; model_clear_all(); acc = 1'b1; end
        end else begin
            case (k)
                8'd18: begin m_st = 3'd0; model_clear_all(); acc = 1'b1; end
                8'd16: begin m_st = 3'd1; m_a = 0; m_b = 0; m_sa = 0; m_sb = 0; acc = 1'b1; end
                8'd15: begin m_st = 3'd2; m_a = 0; m_sa = 0; acc = 1'b1; end
                8'd19: begin m_st = 3'd3; m_b = 0; m_sb = 0; acc = 1'b1; end
                8'd26: begin m_op = 1'b0; acc = 1'b1; end
                8'd30: begin m_op = 1'b1; acc = 1'b1; end
                8'd12: begin
                    if (m_st == 3'd2) begin m_sa = ~m_sa; acc = 1'b1; end
                    else if (m_st == 3'd3) begin m_sb = ~m_sb; acc = 1'b1; end
                end
                default: begin
                    if (k <= 8'd9) begin
                        if (m_st == 3'd2) begin m_a = (m_a % 10) * 10 + k; acc = 1'b1; end
                        else if (m_st == 3'd3) begin m_b = (m_b % 10) * 10 + k; acc = 1'b1; end
                    end
                end
            endcase
        end
    endtask

    // Drives one key press; lat = cycles from validate seen high to key_ack, -1 if none.
    task automatic press(input logic [7:0] k, output int lat);
        bit   acc;
        exp_t e;
        model_key(k, acc);
        if (acc) begin
            e.st = m_st; e.a = m_a; e.b = m_b; e.sa = m_sa; e.sb = m_sb; e.op = m_op;
            sb_q.push_back(e);
        end
        @(negedge clk);
        kp.data     = k;
        kp.validate = 1'b1;
        lat = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (kp.key_ack && lat < 0) lat = i - 1;
        end
        kp.validate = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (kp.key_ack) begin
                if (sb_q.size() == 0) begin
                    check("ack_unexpected", kp.key_ack, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_state", state_o, e.st);
                    check("sb_magA", mag_A, e.a);
                    check("sb_magB", mag_B, e.b);
                    check("sb_signA", signalA, e.sa);
                    check("sb_signB", signalB, e.sb);
                    check("sb_opr", opr, e.op);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        int   ack_cnt;
        bit   found;
        logic [7:0] prev;
        logic [7:0] want;

        // Reset with validate held high
        rst = 1'b1;
        kp.validate = 1'b1;
        kp.data = 8'd18;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (kp.key_ack) ack_cnt++;
        end
        check("rst_no_ack", ack_cnt, 0);
        check("rst_state", state_o, 0);
        check("rst_outA", out_A, 100);
        check("rst_outB", out_B, 100);
        check("rst_magA", mag_A, 0);
        check("rst_opr", opr, 0);
        kp.validate = 1'b0;
        repeat (5) @(negedge clk);

        // Power on and enter A = 73, then shift-in drops tens
        press(8'd18, lat);
        check("lat_first_ack", lat, 3);
        press(8'd15, lat);
        press(8'd4, lat);
        press(8'd7, lat);
        press(8'd3, lat);
        check("t2_state", state_o, 2);
        check("t2_magA", mag_A, 73);
        press(8'd5, lat);
        check("t2_shift_magA", mag_A, 35);

        // Signs, operand B, minus, clear
        press(8'd12, lat);
        press(8'd19, lat);
        press(8'd5, lat);
        press(8'd12, lat);
        press(8'd30, lat);
        check("t3_signA", signalA, 1);
        check("t3_magB", mag_B, 5);
        check("t3_signB", signalB, 1);
        check("t3_opr", opr, 1);
        check("t3_state", state_o, 3);
        press(8'd16, lat);
        check("t3_clr_magA", mag_A, 0);
        check("t3_clr_magB", mag_B, 0);
        check("t3_clr_signA", signalA, 0);
        check("t3_clr_opr", opr, 1);
        check("t3_clr_state", state_o, 1);

        // Digits in IDLE are ignored
        press(8'd7, lat);
        check("idle_digit_ack", (lat >= 0), 0);

        // OFF ignores everything except ON_OFF
        press(8'd18, lat);
        check("off_state", state_o, 0);
        press(8'd5, lat);
        check("off_ack_5", (lat >= 0), 0);
        press(8'd15, lat);
        check("off_ack_15", (lat >= 0), 0);
        press(8'd26, lat);
        check("off_ack_26", (lat >= 0), 0);
        check("off_state_kept", state_o, 0);
        check("off_outA", out_A, 100);
        check("off_outB", out_B, 100);
        press(8'd18, lat);
        check("on_state", state_o, 1);
        check("on_outA", out_A, 0);
        check("on_outB", out_B, 0);

        // Blink: B = 6 shown steady, A = 9 blinking 4 blank / 4 shown
        press(8'd19, lat);
        press(8'd6, lat);
        press(8'd15, lat);
        press(8'd9, lat);
        found = 1'b0;
        prev = out_A;
        for (int i = 0; i < 24 && !found; i++) begin
            @(negedge clk);
            if (prev == 8'd100 && out_A == 8'd9) found = 1'b1;
            else prev = out_A;
        end
        check("blink_sync", found, 1);
        if (found) begin
            for (int c = 1; c < 16; c++) begin
                @(negedge clk);
                want = (((c / 4) % 2) == 0) ? 8'd9 : 8'd100;
                check("blink_outA", out_A, want);
                check("blink_outB", out_B, 6);
            end
        end
        press(8'd16, lat);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("steady_outA", out_A, 0);
            check("steady_outB", out_B, 0);
        end

        // Inactivity behaviour
        press(8'd18, lat);
        press(8'd18, lat);
        repeat (8) @(negedge clk);
        check("idle14_state", state_o, 1);
        repeat (10) @(negedge clk);
`ifdef AUTO_OFF_EN
        check("auto_off_state", state_o, 0);
        check("auto_off_outA", out_A, 100);
        m_st = 3'd0;
        model_clear_all();
        press(8'd18, lat);
        repeat (5) @(negedge clk);
        press(8'd26, lat);
        repeat (3) @(negedge clk);
        check("auto_kept_state", state_o, 1);
        repeat (15) @(negedge clk);
        check("auto_off2_state", state_o, 0);
        m_st = 3'd0;
        model_clear_all();
`else
        check("no_auto_off_state", state_o, 1);
        check("no_auto_off_outA", out_A, 0);
`endif

        repeat (4) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
